operand_loader: RTL and testbench

Upstream input stage for the logic/ALU datapath. It turns the board's slide switches and two raw pushbuttons into registered operands: x, y, z and the 2-bit operation select. Each key is debounced and edge-detected. A four-state sequencer steps the user through operand entry. The outputs drive the logical unit's x, y, z and operation inputs directly, and valid tells the display path that a complete operand set is loaded.

---
 rtl/operand_loader_pkg.sv | 19 +
 rtl/key_debouncer.sv | 55 +++++
 rtl/operand_loader.sv | 101 ++++++++++
 tb/tb_operand_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared codes for the operand loader and the logical unit it feeds.
// Stage codes appear on the status output. Operation codes select the ALU function.
package operand_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_X  = 2'b00,
        LOAD_Y  = 2'b01,
        LOAD_OP = 2'b10,
        READY   = 2'b11
    } stage_e;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

endpackage

// File: rtl/key_debouncer.sv
// Raw pushbutton to one-cycle press pulse: 2-FF synchronizer, stability counter,
// and a registered rising-edge detector. Releases are filtered but never pulse.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             hist_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            hist_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            hist_q  <= level_q;
            press_q <= level_q & ~hist_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// Sequencer that walks the user through x/z, y and operation entry from the
// slide switches, one debounced load press per step; a clear press restarts.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    input  logic       key_load,
    input  logic       key_clear,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [7:0] z,
    output logic [1:0] operation,
    output logic       valid,
    output logic [1:0] stage
);

    logic       load_press, clear_press;
    stage_e     state_q, state_d;
    logic [3:0] x_q, x_d, y_q, y_d;
    logic [7:0] z_q, z_d;
    op_e        op_q, op_d;
    logic       valid_q, valid_d;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk   (clk),
        .reset (reset),
        .raw   (key_load),
        .press (load_press)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk   (clk),
        .reset (reset),
        .raw   (key_clear),
        .press (clear_press)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        op_d    = op_q;
        // Clear outranks a coincident load, which is simply dropped.
        if (clear_press) begin
            state_d = LOAD_X;
            x_d     = '0;
            y_d     = '0;
            z_d     = '0;
            op_d    = OP_AND;
        end else if (load_press) begin
            case (state_q)
                LOAD_X: begin
                    x_d     = sw[3:0];
                    z_d     = sw;
                    state_d = LOAD_Y;
                end
                LOAD_Y: begin
                    y_d     = sw[3:0];
                    state_d = LOAD_OP;
                end
                LOAD_OP: begin
                    op_d    = op_e'(sw[1:0]);
                    state_d = READY;
                end
                default: state_d = LOAD_X;
            endcase
        end
        valid_d = (state_d == READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_X;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            op_q    <= OP_AND;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;
    assign operation = op_q;
    assign valid     = valid_q;
    assign stage     = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with a short debounce window: directed
// table, latency and corner sequences, then random presses against a step model.
module tb_operand_loader;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic       key_load, key_clear;
    logic [3:0] x, y;
    logic [7:0] z;
    logic [1:0] operation, stage;
    logic       valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: abstract entry step 0..3 plus the operand values.
    int m_step, m_x, m_y, m_z, m_op;

    typedef struct {
        logic [7:0] sw;
        bit         ld;
        bit         clr;
        logic [3:0] ex;
        logic [3:0] ey;
        logic [7:0] ez;
        logic [1:0] eop;
        logic [1:0] est;
        logic       ev;
    } vec_t;

    vec_t vecs[6];

    operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .key_load  (key_load),
        .key_clear (key_clear),
        .x         (x),
        .y         (y),
        .z         (z),
        .operation (operation),
        .valid     (valid),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ex, input int ey, input int ez,
                             input int eop, input int est, input int ev);
        check({tag, ".x"},     32'(x),         32'(ex));
        check({tag, ".y"},     32'(y),         32'(ey));
        check({tag, ".z"},     32'(z),         32'(ez));
        check({tag, ".op"},    32'(operation), 32'(eop));
        check({tag, ".stage"}, 32'(stage),     32'(est));
        check({tag, ".valid"}, 32'(valid),     32'(ev));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_load = 1'b0;
        key_clear = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        m_step = 0; m_x = 0; m_y = 0; m_z = 0; m_op = 0;
    endtask

    // Hold the selected keys high for `hold` cycles, then low for a settling gap.
    task automatic press(input bit ld, input bit clr, input int hold);
        key_load  = ld;
        key_clear = clr;
        tick(hold);
        key_load  = 1'b0;
        key_clear = 1'b0;
        tick(10);
    endtask

    task automatic model_event(input bit ld, input bit clr, input logic [7:0] s);
        if (clr) begin
            m_step = 0; m_x = 0; m_y = 0; m_z = 0; m_op = 0;
        end else if (ld) begin
            case (m_step)
                0: begin m_x = int'(s) % 16; m_z = int'(s); end
                1: m_y  = int'(s) % 16;
                2: m_op = int'(s) % 4;
                default: ;
            endcase
            m_step = (m_step + 1) % 4;
        end
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_x, m_y, m_z, m_op, m_step, (m_step == 3) ? 1 : 0);
    endtask

    initial begin
        vecs[0] = '{sw: 8'hA5, ld: 1, clr: 0, ex: 4'h5, ey: 4'h0, ez: 8'hA5, eop: 2'b00, est: 2'b01, ev: 1'b0};
        vecs[1] = '{sw: 8'h03, ld: 1, clr: 0, ex: 4'h5, ey: 4'h3, ez: 8'hA5, eop: 2'b00, est: 2'b10, ev: 1'b0};
        vecs[2] = '{sw: 8'h02, ld: 1, clr: 0, ex: 4'h5, ey: 4'h3, ez: 8'hA5, eop: 2'b10, est: 2'b11, ev: 1'b1};
        vecs[3] = '{sw: 8'h77, ld: 1, clr: 0, ex: 4'h5, ey: 4'h3, ez: 8'hA5, eop: 2'b10, est: 2'b00, ev: 1'b0};
        vecs[4] = '{sw: 8'h9E, ld: 1, clr: 0, ex: 4'hE, ey: 4'h3, ez: 8'h9E, eop: 2'b10, est: 2'b01, ev: 1'b0};
        vecs[5] = '{sw: 8'h3C, ld: 0, clr: 1, ex: 4'h0, ey: 4'h0, ez: 8'h00, eop: 2'b00, est: 2'b00, ev: 1'b0};

        sw = 8'h00;
        do_reset();
        check_all("reset", 0, 0, 0, 0, 0, 0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            sw = vecs[i].sw;
            press(vecs[i].ld, vecs[i].clr, 8);
            check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ez,
                      vecs[i].eop, vecs[i].est, vecs[i].ev);
        end

        // Latency: rise first sampled at edge 0, capture visible after edge D+3.
        do_reset();
        sw = 8'h96;
        key_load = 1'b1;
        tick(D + 3);
        check("lat.before.x", 32'(x), 32'h0);
        check("lat.before.stage", 32'(stage), 32'h0);
        tick(1);
        check("lat.at.x", 32'(x), 32'h6);
        check("lat.at.stage", 32'(stage), 32'h1);
        key_load = 1'b0;
        tick(10);

        // Bounce rejection, then one clean hold.
        do_reset();
        sw = 8'h4B;
        for (int i = 0; i < 20; i++) begin
            key_load = ((i / 3) % 2 == 0);
            tick(1);
        end
        key_load = 1'b0;
        tick(10);
        check_all("bounce", 0, 0, 0, 0, 0, 0);
        press(1'b1, 1'b0, 10);
        check_all("bounce.hold", 4'hB, 0, 8'h4B, 0, 1, 0);

        // Held key advances only one step.
        do_reset();
        sw = 8'hC7;
        press(1'b1, 1'b0, 50);
        check_all("held", 4'h7, 0, 8'hC7, 0, 1, 0);

        // Clear wins over a simultaneous load in READY.
        do_reset();
        sw = 8'h21; press(1'b1, 1'b0, 8);
        sw = 8'h0A; press(1'b1, 1'b0, 8);
        sw = 8'h01; press(1'b1, 1'b0, 8);
        check_all("prio.ready", 4'h1, 4'hA, 8'h21, 1, 3, 1);
        sw = 8'hFF;
        press(1'b1, 1'b1, 8);
        check_all("prio.clear", 0, 0, 0, 0, 0, 0);

        // Reset during a debounce count in LOAD_Y discards the pending press.
        do_reset();
        sw = 8'h58; press(1'b1, 1'b0, 8);
        sw = 8'h0F;
        key_load = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        key_load = 1'b0;
        tick(10);
        check_all("rstmid", 0, 0, 0, 0, 0, 0);
        sw = 8'h3C;
        press(1'b1, 1'b0, 8);
        check_all("rstmid.repress", 4'hC, 0, 8'h3C, 0, 1, 0);

        // Random presses, glitches and clears against the model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            sw = 8'($urandom_range(0, 255));
            if (kind <= 5) begin
                press(1'b1, 1'b0, int'($urandom_range(5, 12)));
                model_event(1'b1, 1'b0, sw);
            end else if (kind == 6) begin
                press(1'b0, 1'b1, int'($urandom_range(5, 12)));
                model_event(1'b0, 1'b1, sw);
            end else if (kind == 7) begin
                press(1'b1, 1'b1, int'($urandom_range(5, 12)));
                model_event(1'b1, 1'b1, sw);
            end else begin
                // Glitch shorter than the debounce window: no effect.
                if (kind == 8) press(1'b1, 1'b0, int'($urandom_range(1, D - 1)));
                else           press(1'b0, 1'b1, int'($urandom_range(1, D - 1)));
            end
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
